// File: rtl/z80_resp_pkg.sv
// z80_resp_pkg: shared FSM states and cycle-type encoding for the Z80 bus responder.
package z80_resp_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_INTA} state_t;

    // Cycle type is {io, we}
    localparam logic [1:0] CYC_MEMRD = 2'b00;
    localparam logic [1:0] CYC_MEMWR = 2'b01;
    localparam logic [1:0] CYC_IORD  = 2'b10;
    localparam logic [1:0] CYC_IOWR  = 2'b11;

    // Returns {valid, io, we}; refresh and interrupt-acknowledge never decode as a bus cycle
    function automatic logic [2:0] decode_cycle(input logic mreq_n, input logic iorq_n,
                                                 input logic rd_n, input logic wr_n,
                                                 input logic rfsh_n, input logic m1_n);
        logic mem, io;
        mem = !mreq_n & rfsh_n;
        io  = !iorq_n & m1_n;
        return (!rd_n & mem) ? {1'b1, CYC_MEMRD} :
               (!wr_n & mem) ? {1'b1, CYC_MEMWR} :
               (!rd_n & io)  ? {1'b1, CYC_IORD}  :
               (!wr_n & io)  ? {1'b1, CYC_IOWR}  : 3'b000;
    endfunction

endpackage

// File: rtl/z80_resp_intc.sv
// z80_resp_intc: interrupt-pending flag and nINT; a request on the acknowledge edge keeps pending set.
module z80_resp_intc (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_int_req,
    input  logic i_inta,
    output logic o_nint
);

    logic r_pending;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) r_pending <= 1'b0;
        else         r_pending <= i_int_req | (r_pending & !i_inta);
    end

    assign o_nint = !r_pending;

endmodule

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: turns Z80 bus cycles into backend requests with nWAIT stretching.
// Interrupt acknowledge support is built only when Z80_RESP_INTACK_EN is defined.
module z80_bus_responder
    import z80_resp_pkg::*;
#(
    parameter int         WAIT_MIN   = 0,
    parameter logic [7:0] INT_VECTOR = 8'hFF
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] A,
    inout  wire  [7:0]  D,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    output logic        nWAIT,
    output logic        nINT,
    output logic        bk_req,
    output logic        bk_we,
    output logic        bk_io,
    output logic [15:0] bk_addr,
    output logic [7:0]  bk_wdata,
    input  logic [7:0]  bk_rdata,
    input  logic        bk_ack,
    input  logic        int_req,
    output logic        busy
);

    state_t     r_state, w_next;
    logic [3:0] r_cnt;
    logic [7:0] r_rdata;
    logic [2:0] w_cyc;
    logic       w_start, w_release, w_inta_go, w_d_oe;
    logic [7:0] w_d_out;

    assign w_cyc     = decode_cycle(nMREQ, nIORQ, nRD, nWR, nRFSH, nM1);
    assign w_start   = (r_state == S_IDLE) & w_cyc[2];
    // bk_req low inside REQ means the ack has already been taken
    assign w_release = (!bk_req | bk_ack) & (r_cnt <= 4'd1);

`ifdef Z80_RESP_INTACK_EN
    assign w_inta_go = (r_state == S_IDLE) & !w_cyc[2] & !nIORQ & !nM1;

    z80_resp_intc u_intc (
        .i_clk     (CLK),
        .i_nrst    (nRESET),
        .i_int_req (int_req),
        .i_inta    (w_inta_go),
        .o_nint    (nINT)
    );
`else
    logic w_unused_int;
    assign w_unused_int = int_req;
    assign w_inta_go    = 1'b0;
    assign nINT         = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (!nRESET) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_cyc[2] ? S_REQ : w_inta_go ? S_INTA : S_IDLE;
            S_REQ:   w_next = w_release ? S_HOLD : S_REQ;
            S_HOLD:  w_next = (nRD & nWR) ? S_IDLE : S_HOLD;
            S_INTA:  w_next = nIORQ ? S_IDLE : S_INTA;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            bk_req   <= 1'b0;
            bk_we    <= 1'b0;
            bk_io    <= 1'b0;
            bk_addr  <= '0;
            bk_wdata <= '0;
            nWAIT    <= 1'b1;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else if (w_start) begin
            bk_addr  <= A;
            bk_wdata <= D;
            bk_we    <= w_cyc[0];
            bk_io    <= w_cyc[1];
            bk_req   <= 1'b1;
            nWAIT    <= 1'b0;
            r_cnt    <= 4'(WAIT_MIN);
        end else if (r_state == S_REQ) begin
            r_cnt <= (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
            if (bk_req && bk_ack) begin
                bk_req  <= 1'b0;
                r_rdata <= bk_rdata;
            end
            if (w_release) nWAIT <= 1'b1;
        end
    end

    assign w_d_oe  = ((r_state == S_HOLD) & !bk_we) | (r_state == S_INTA);
    assign w_d_out = (r_state == S_INTA) ? INT_VECTOR : r_rdata;
    assign D       = w_d_oe ? w_d_out : 8'hzz;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder: randomized bus cycles on two responders (WAIT_MIN 0 and 3)
// checked against a transaction-level model of wait, request and data timing.
module tb_z80_bus_responder;

`ifdef Z80_RESP_INTACK_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       nrst, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, ack, intr, d_oe, pend;
    logic [1:0][15:0] a;
    logic [1:0][7:0]  rdata, d_drv;
    wire  [1:0]       nwait, nint, req, we, io, busy;
    wire  [1:0][15:0] baddr;
    wire  [1:0][7:0]  bwdata;
    wire  [7:0]       d0, d1;

    assign d0 = d_oe[0] ? d_drv[0] : 8'hzz;
    assign d1 = d_oe[1] ? d_drv[1] : 8'hzz;

    int n_tests = 0;
    int n_fail  = 0;

    z80_bus_responder #(.WAIT_MIN(0), .INT_VECTOR(8'hFF)) u_dut0 (
        .CLK(clk), .nRESET(nrst[0]), .A(a[0]), .D(d0),
        .nM1(m1_n[0]), .nMREQ(mreq_n[0]), .nIORQ(iorq_n[0]), .nRD(rd_n[0]), .nWR(wr_n[0]), .nRFSH(rfsh_n[0]),
        .nWAIT(nwait[0]), .nINT(nint[0]), .bk_req(req[0]), .bk_we(we[0]), .bk_io(io[0]),
        .bk_addr(baddr[0]), .bk_wdata(bwdata[0]), .bk_rdata(rdata[0]), .bk_ack(ack[0]),
        .int_req(intr[0]), .busy(busy[0])
    );

    z80_bus_responder #(.WAIT_MIN(3), .INT_VECTOR(8'h5A)) u_dut3 (
        .CLK(clk), .nRESET(nrst[1]), .A(a[1]), .D(d1),
        .nM1(m1_n[1]), .nMREQ(mreq_n[1]), .nIORQ(iorq_n[1]), .nRD(rd_n[1]), .nWR(wr_n[1]), .nRFSH(rfsh_n[1]),
        .nWAIT(nwait[1]), .nINT(nint[1]), .bk_req(req[1]), .bk_we(we[1]), .bk_io(io[1]),
        .bk_addr(baddr[1]), .bk_wdata(bwdata[1]), .bk_rdata(rdata[1]), .bk_ack(ack[1]),
        .int_req(intr[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dval(input int k);
        return k ? d1 : d0;
    endfunction

    function automatic logic released(input logic [7:0] v);
        return (v === 8'hzz) || (v === 8'h00);
    endfunction

    function automatic logic exp_nint(input int k);
        return INT_EN ? !pend[k] : 1'b1;
    endfunction

    task automatic idle_bus(input int k);
        m1_n[k] = 1'b1; mreq_n[k] = 1'b1; iorq_n[k] = 1'b1;
        rd_n[k] = 1'b1; wr_n[k] = 1'b1; rfsh_n[k] = 1'b1;
        d_oe[k] = 1'b0; ack[k] = 1'b0; intr[k] = 1'b0;
    endtask

    // kind = {io, we}; the backend acks on REQ cycle number dly (1 = first)
    task automatic bus_cycle(input int k, input logic [1:0] kind, input logic [15:0] addr,
                             input logic [7:0] wd, input logic [7:0] rd, input int dly);
        int  nlow, nreq, exp_low;
        bit  stable, dz, done;
        exp_low = (k ? 3 : 0) > dly ? (k ? 3 : 0) : dly;
        @(negedge clk);
        a[k] = addr;
        if (kind[1]) iorq_n[k] = 1'b0; else mreq_n[k] = 1'b0;
        if (kind[0]) begin wr_n[k] = 1'b0; d_drv[k] = wd; d_oe[k] = 1'b1; end
        else rd_n[k] = 1'b0;
        nlow = 0; nreq = 0; stable = 1'b1; dz = 1'b1; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                d_oe[k] = 1'b0;
                check("bk_addr", 32'(baddr[k]), 32'(addr));
                check("bk_we", 32'(we[k]), 32'(kind[0]));
                check("bk_io", 32'(io[k]), 32'(kind[1]));
                if (kind[0]) check("bk_wdata", 32'(bwdata[k]), 32'(wd));
            end else if (req[k]) begin
                stable &= (baddr[k] == addr) && (we[k] == kind[0]) && (io[k] == kind[1]);
            end
            if (!nwait[k] && i > 0) dz &= released(dval(k));
            nlow += int'(!nwait[k]);
            nreq += int'(req[k]);
            done = nwait[k];
            ack[k]   = (i + 1 == dly);
            rdata[k] = (i + 1 == dly) ? rd : 8'($urandom);
        end
        ack[k] = 1'b0;
        check("wait_released", 32'(done), 1);
        check("nwait_low_cycles", 32'(nlow), 32'(exp_low));
        check("bk_req_cycles", 32'(nreq), 32'(dly));
        check("fields_stable", 32'(stable), 1);
        check("d_released_in_req", 32'(dz), 1);
        check("hold_busy", 32'(busy[k]), 1);
        if (!kind[0]) check("hold_d", 32'(dval(k)), 32'(rd));
        else          check("hold_d_write_z", 32'(released(dval(k))), 1);
        ack[k] = 1'b1; rdata[k] = ~rd;
        @(negedge clk);
        ack[k] = 1'b0;
        check("hold_ack_ignored_req", 32'(req[k]), 0);
        if (!kind[0]) check("hold_ack_ignored_d", 32'(dval(k)), 32'(rd));
        rd_n[k] = 1'b1; wr_n[k] = 1'b1; mreq_n[k] = 1'b1; iorq_n[k] = 1'b1;
        @(negedge clk);
        check("end_busy", 32'(busy[k]), 0);
        check("end_d_z", 32'(released(dval(k))), 1);
    endtask

    task automatic refresh(input int k);
        bit ok;
        ok = 1'b1;
        @(negedge clk);
        a[k] = 16'h007F; mreq_n[k] = 1'b0; rfsh_n[k] = 1'b0; rd_n[k] = 1'($urandom);
        ack[k] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ack[k] = 1'b0;
            ok &= !req[k] && nwait[k] && !busy[k];
        end
        check("refresh_ignored", 32'(ok), 1);
        idle_bus(k);
    endtask

    task automatic intack(input int k, input bit same);
        @(negedge clk);
        intr[k] = 1'b1;
        @(negedge clk);
        intr[k] = 1'b0; pend[k] = 1'b1;
        check("nint_pending", 32'(nint[k]), 32'(exp_nint(k)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check("nint_held", 32'(nint[k]), 32'(exp_nint(k)));
        iorq_n[k] = 1'b0; m1_n[k] = 1'b0; intr[k] = same;
        @(negedge clk);
        intr[k] = 1'b0; pend[k] = same;
        check("inta_nint", 32'(nint[k]), 32'(exp_nint(k)));
        check("inta_nwait", 32'(nwait[k]), 1);
        check("inta_no_req", 32'(req[k]), 0);
        check("inta_busy", 32'(busy[k]), 32'(INT_EN));
        if (INT_EN) check("inta_vector", 32'(dval(k)), k ? 32'h5A : 32'hFF);
        else        check("inta_d_z", 32'(released(dval(k))), 1);
        @(negedge clk);
        if (INT_EN) check("inta_vector_hold", 32'(dval(k)), k ? 32'h5A : 32'hFF);
        iorq_n[k] = 1'b1; m1_n[k] = 1'b1;
        @(negedge clk);
        check("inta_end_busy", 32'(busy[k]), 0);
        check("inta_end_d_z", 32'(released(dval(k))), 1);
        check("inta_end_nint", 32'(nint[k]), 32'(exp_nint(k)));
    endtask

    task automatic reset_mid(input int k);
        @(negedge clk);
        intr[k] = 1'b1;
        @(negedge clk);
        intr[k] = 1'b0; pend[k] = 1'b1;
        a[k] = 16'($urandom); mreq_n[k] = 1'b0; rd_n[k] = 1'b0;
        @(negedge clk);
        check("pre_rst_req", 32'(req[k]), 1);
        check("pre_rst_nint", 32'(nint[k]), 32'(exp_nint(k)));
        nrst[k] = 1'b0;
        idle_bus(k);
        @(negedge clk);
        pend[k] = 1'b0;
        check("rst_req", 32'(req[k]), 0);
        check("rst_nwait", 32'(nwait[k]), 1);
        check("rst_busy", 32'(busy[k]), 0);
        check("rst_fields", {we[k], io[k], bwdata[k], baddr[k]}, 0);
        check("rst_nint", 32'(nint[k]), 1);
        check("rst_d_z", 32'(released(dval(k))), 1);
        nrst[k] = 1'b1; ack[k] = 1'b1; rdata[k] = 8'($urandom);
        @(negedge clk);
        ack[k] = 1'b0;
        check("late_ack_req", 32'(req[k]), 0);
        check("late_ack_busy", 32'(busy[k]), 0);
        check("late_ack_nwait", 32'(nwait[k]), 1);
    endtask

    initial begin
        nrst = '0; a = '0; rdata = '0; d_drv = '0; pend = '0;
        idle_bus(0);
        idle_bus(1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_nwait", 32'(nwait[k]), 1);
            check("reset_nint", 32'(nint[k]), 1);
            check("reset_req", 32'(req[k]), 0);
            check("reset_busy", 32'(busy[k]), 0);
            check("reset_addr", 32'(baddr[k]), 0);
        end
        nrst = 2'b11;
        bus_cycle(0, 2'b00, 16'h1234, 8'h00, 8'hA5, 1);
        bus_cycle(1, 2'b11, 16'h00FE, 8'h3C, 8'h00, 1);
        bus_cycle(0, 2'b00, 16'hBEEF, 8'h00, 8'h77, 5);
        for (int k = 0; k < 2; k++) begin
            refresh(k);
            intack(k, 1'b0);
            intack(k, 1'b1);
            intack(k, 1'b0);
            reset_mid(k);
        end
        for (int n = 0; n < 50; n++) begin
            bus_cycle($urandom_range(0, 1), 2'($urandom_range(0, 3)), 16'($urandom),
                      8'($urandom), 8'($urandom_range(1, 255)), $urandom_range(1, 6));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
